mio_bus_hs: RTL and testbench

Parametrised, handshaked successor to the CPU memory-mapped I/O bus decoder. Sits between the CPU data port and NUM_SLV peripheral slaves (data RAM, GPIO, counter, VGA RAM, PS/2, sprite ROMs). Replaces the fixed single-cycle nibble decode with:

- a req/ready handshake;
- per-slave acknowledge, so slaves may insert wait states;
- bus-error reporting for unmapped addresses;
- an optional access timeout.

---
 rtl/mio_bus_pkg.sv | 30 +++
 rtl/mio_bus_timeout.sv | 33 +++
 rtl/mio_bus_hs.sv | 183 ++++++++++++++++++
 tb/tb_mio_bus_hs.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_bus_pkg.sv
// Shared definitions for the handshaked MIO bus decoder: FSM state encoding,
// region nibbles of the peripheral map, the default slave region map and
// an address helper.
package mio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] RGN_RAM  = 4'h0;
  localparam logic [3:0] RGN_WALL = 4'h9;
  localparam logic [3:0] RGN_CHAR = 4'ha;
  localparam logic [3:0] RGN_BG   = 4'hb;
  localparam logic [3:0] RGN_VRAM = 4'hc;
  localparam logic [3:0] RGN_KBD  = 4'hd;
  localparam logic [3:0] RGN_SEG  = 4'he;
  localparam logic [3:0] RGN_GPIO = 4'hf;

  // Slave 0 sits in the least significant nibble.
  localparam logic [31:0] DEF_REGION_MAP = {RGN_WALL, RGN_CHAR, RGN_BG, RGN_VRAM,
                                            RGN_KBD, RGN_SEG, RGN_GPIO, RGN_RAM};

  // Region nibble of a CPU byte address.
  function automatic logic [3:0] region_of(input logic [31:0] addr);
    return addr[31:28];
  endfunction

endpackage

// File: rtl/mio_bus_timeout.sv
// Access watchdog for the MIO bus: counts enabled cycles from a clear and
// flags expiry once TIMEOUT cycles have elapsed. Only built when
// MIO_BUS_TIMEOUT_EN is defined.
module mio_bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter: restarts on clr, stops at the expiry value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && !expired) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mio_bus_hs.sv
// Handshaked CPU memory-mapped I/O bus decoder. Decodes cpu_addr[31:28]
// against REGION_MAP (lowest slave index wins), holds the selected slave
// until it acknowledges, and reports unmapped accesses as bus errors.
// Optional access timeout: define MIO_BUS_TIMEOUT_EN.
module mio_bus_hs
  import mio_bus_pkg::*;
#(
  parameter int                      NUM_SLV    = 8,
  parameter int                      DATA_W     = 32,
  parameter int                      SLV_ADDR_W = 18,
  parameter logic [NUM_SLV*4-1:0]    REGION_MAP = DEF_REGION_MAP,
  parameter int                      TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [31:0]               cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_ready,
  output logic                      cpu_err,
  output logic [NUM_SLV-1:0]        slv_sel,
  output logic                      slv_we,
  output logic [SLV_ADDR_W-1:0]     slv_addr,
  output logic [DATA_W-1:0]         slv_wdata,
  input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLV-1:0]        slv_ack,
  output logic [7:0]                err_cnt
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  state_e             state_r, state_nxt_s;
  logic [IDX_W-1:0]   sel_idx_r;
  logic [IDX_W-1:0]   hit_idx_s;
  logic               hit_s;
  logic               sel_ack_s;
  logic [DATA_W-1:0]  sel_rdata_s;
  logic               go_hit_s, go_miss_s, done_ack_s, done_to_s;
  logic               to_exp_s;
  logic               addr_unused_s;

  // Middle address bits are neither decoded nor forwarded.
  assign addr_unused_s = ^cpu_addr;

`ifdef MIO_BUS_TIMEOUT_EN
  logic to_clr_s, to_en_s;
  assign to_clr_s = go_hit_s;
  assign to_en_s  = (state_r == ST_ACCESS);

  mio_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr_s),
    .en      (to_en_s),
    .expired (to_exp_s)
  );
`else
  // No watchdog: the expression is constant false, ACCESS waits for an ack.
  assign to_exp_s = (TIMEOUT < 0);
`endif

  // Region priority encoder: scanning downward lets the lowest index win.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (region_of(cpu_addr) == REGION_MAP[4*i +: 4]) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_W'(i);
      end else begin
        hit_s     = hit_s;
        hit_idx_s = hit_idx_s;
      end
    end
  end

  // Pick ack and read data of the selected slave; others are ignored.
  always_comb begin
    sel_ack_s   = 1'b0;
    sel_rdata_s = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_idx_r == IDX_W'(i)) begin
        sel_ack_s   = slv_ack[i];
        sel_rdata_s = slv_rdata[DATA_W*i +: DATA_W];
      end else begin
        sel_ack_s   = sel_ack_s;
        sel_rdata_s = sel_rdata_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and transition events; an ack beats a same-cycle expiry.
  always_comb begin
    state_nxt_s = state_r;
    go_hit_s    = 1'b0;
    go_miss_s   = 1'b0;
    done_ack_s  = 1'b0;
    done_to_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req && hit_s) begin
          go_hit_s    = 1'b1;
          state_nxt_s = ST_ACCESS;
        end else if (cpu_req) begin
          go_miss_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (sel_ack_s) begin
          done_ack_s  = 1'b1;
          state_nxt_s = ST_RESP;
        end else if (to_exp_s) begin
          done_to_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Registered bus outputs, response and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_idx_r <= '0;
      slv_sel   <= '0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      err_cnt   <= 8'h00;
    end else begin
      cpu_ready <= go_miss_s | done_ack_s | done_to_s;

      if (go_hit_s) begin
        sel_idx_r <= hit_idx_s;
        slv_sel   <= NUM_SLV'(1) << hit_idx_s;
        slv_we    <= cpu_we;
        slv_addr  <= cpu_addr[SLV_ADDR_W-1:0];
        slv_wdata <= cpu_wdata;
      end else if (done_ack_s || done_to_s) begin
        slv_sel   <= '0;
      end

      if (go_miss_s || done_to_s) begin
        cpu_err   <= 1'b1;
        cpu_rdata <= '0;
      end else if (done_ack_s) begin
        cpu_err   <= 1'b0;
        cpu_rdata <= slv_we ? '0 : sel_rdata_s;
      end else if (state_r == ST_RESP) begin
        cpu_err   <= 1'b0;
      end

      if ((state_r == ST_RESP) && cpu_err && (err_cnt != 8'hff)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mio_bus_hs.sv
// Directed self-checking bench for mio_bus_hs. Inputs change and outputs are
// sampled on the falling edge; cycle n is the period ending at the n-th
// sampling rising edge after the request is driven.
module tb_mio_bus_hs;

  localparam int NUM_SLV = 8;
  localparam int DATA_W  = 32;
  localparam int AW      = 18;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      cpu_req;
  logic                      cpu_we;
  logic [31:0]               cpu_addr;
  logic [DATA_W-1:0]         cpu_wdata;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_ready;
  logic                      cpu_err;
  logic [NUM_SLV-1:0]        slv_sel;
  logic                      slv_we;
  logic [AW-1:0]             slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [NUM_SLV*DATA_W-1:0] slv_rdata;
  logic [NUM_SLV-1:0]        slv_ack;
  logic [7:0]                err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mio_bus_hs #(.NUM_SLV(NUM_SLV), .DATA_W(DATA_W), .SLV_ADDR_W(AW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata), .slv_ack(slv_ack), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cpu_ready, cpu_err, slv_we, slv_sel} !== 11'h000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {cpu_ready, cpu_err, slv_we, slv_sel});
    end
    n_checks++;
    if ({cpu_rdata, slv_wdata, slv_addr, err_cnt} !== 90'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {cpu_rdata, slv_wdata, slv_addr, err_cnt});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    slv_rdata[0 +: DATA_W] = 32'h1234_5678;
    @(negedge clk); // cycle 1
    n_checks++;
    if (slv_sel !== 8'h01 || slv_addr !== 18'h10 || slv_we !== 1'b0 || cpu_ready !== 1'b0) begin
      n_fail++; $display("FAIL read_select: sel=%h addr=%h we=%b rdy=%b expected 01/10/0/0", slv_sel, slv_addr, slv_we, cpu_ready);
    end
    slv_ack = 8'h01;
    @(negedge clk); // cycle 2
    n_checks++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h1234_5678 || slv_sel !== 8'h00) begin
      n_fail++; $display("FAIL read_resp: rdy=%b err=%b rdata=%h sel=%h expected 1/0/12345678/00", cpu_ready, cpu_err, cpu_rdata, slv_sel);
    end
    slv_ack = 8'h00; cpu_req = 1'b0;
    @(negedge clk); // cycle 3
    n_checks++;
    if (cpu_ready !== 1'b0) begin
      n_fail++; $display("FAIL read_pulse_width: rdy=%b expected 0", cpu_ready);
    end
  endtask

  task automatic test_write_wait();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hC000_0100; cpu_wdata = 32'h0000_0abc;
    slv_rdata[4*DATA_W +: DATA_W] = 32'hdead_beef;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (slv_sel !== 8'h10 || slv_we !== 1'b1 || slv_wdata !== 32'h0000_0abc ||
          slv_addr !== 18'h100 || cpu_ready !== 1'b0) begin
        n_fail++; $display("FAIL write_hold c%0d: sel=%h we=%b wd=%h addr=%h rdy=%b expected 10/1/00000abc/100/0",
                           c, slv_sel, slv_we, slv_wdata, slv_addr, cpu_ready);
      end
      // an unselected slave acks in cycle 2; slave 4 acks in cycle 4
      slv_ack = (c == 2) ? 8'h01 : ((c == 4) ? 8'h10 : 8'h00);
    end
    @(negedge clk); // cycle 5
    n_checks++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0 || slv_sel !== 8'h00) begin
      n_fail++; $display("FAIL write_resp: rdy=%b err=%b rdata=%h sel=%h expected 1/0/0/00", cpu_ready, cpu_err, cpu_rdata, slv_sel);
    end
    slv_ack = 8'h00; cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_ready !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL write_after: rdy=%b err_cnt=%0d expected 0/0", cpu_ready, err_cnt);
    end
  endtask

  task automatic test_unmapped();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5000_0000;
    @(negedge clk); // cycle 1
    n_checks++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'h0 || slv_sel !== 8'h00) begin
      n_fail++; $display("FAIL unmapped_resp: rdy=%b err=%b rdata=%h sel=%h expected 1/1/0/00", cpu_ready, cpu_err, cpu_rdata, slv_sel);
    end
    cpu_req = 1'b0;
    @(negedge clk); // cycle 2
    n_checks++;
    if (err_cnt !== 8'd1 || cpu_ready !== 1'b0 || cpu_err !== 1'b0 || slv_sel !== 8'h00) begin
      n_fail++; $display("FAIL unmapped_after: cnt=%0d rdy=%b err=%b sel=%h expected 1/0/0/00", err_cnt, cpu_ready, cpu_err, slv_sel);
    end
  endtask

`ifdef MIO_BUS_TIMEOUT_EN
  task automatic test_timeout();
    logic ok;
    // no ack: expiry after TIMEOUT=4 counts, error response in cycle 6
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hD000_0000;
    ok = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (slv_sel !== 8'h08 || cpu_ready !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL timeout_wait: ok=%b expected 1", ok);
    end
    @(negedge clk); // cycle 6
    n_checks++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'h0 || slv_sel !== 8'h00) begin
      n_fail++; $display("FAIL timeout_resp: rdy=%b err=%b rdata=%h sel=%h expected 1/1/0/00", cpu_ready, cpu_err, cpu_rdata, slv_sel);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_cnt !== 8'd2) begin
      n_fail++; $display("FAIL timeout_cnt: got %0d expected 2", err_cnt);
    end
    // ack in the expiry cycle: normal completion
    @(negedge clk);
    cpu_req = 1'b1;
    slv_rdata[3*DATA_W +: DATA_W] = 32'hcafe_f00d;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      slv_ack = (c == 5) ? 8'h08 : 8'h00;
    end
    @(negedge clk); // cycle 6
    n_checks++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'hcafe_f00d) begin
      n_fail++; $display("FAIL timeout_ack_wins: rdy=%b err=%b rdata=%h expected 1/0/cafef00d", cpu_ready, cpu_err, cpu_rdata);
    end
    slv_ack = 8'h00; cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_cnt !== 8'd2) begin
      n_fail++; $display("FAIL timeout_ack_cnt: got %0d expected 2", err_cnt);
    end
  endtask
`else
  task automatic test_timeout();
    logic ok;
    // without the watchdog the access waits for an ack indefinitely
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hD000_0000;
    slv_rdata[3*DATA_W +: DATA_W] = 32'hcafe_f00d;
    ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (slv_sel !== 8'h08 || cpu_ready !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL no_timeout_wait: ok=%b expected 1", ok);
    end
    slv_ack = 8'h08;
    @(negedge clk);
    n_checks++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'hcafe_f00d) begin
      n_fail++; $display("FAIL no_timeout_resp: rdy=%b err=%b rdata=%h expected 1/0/cafef00d", cpu_ready, cpu_err, cpu_rdata);
    end
    slv_ack = 8'h00; cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL no_timeout_cnt: got %0d expected 1", err_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic ok;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hF000_0004; cpu_wdata = 32'h5555_aaaa;
    @(negedge clk); // cycle 1
    n_checks++;
    if (slv_sel !== 8'h02) begin
      n_fail++; $display("FAIL rstmid_select: sel=%h expected 02", slv_sel);
    end
    @(negedge clk); // cycle 2, wait state
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cpu_ready, cpu_err, slv_we, slv_sel, cpu_rdata, slv_wdata, slv_addr, err_cnt} !== 101'h0) begin
      n_fail++; $display("FAIL rstmid_async: sel=%h we=%b wd=%h addr=%h cnt=%0d expected all 0", slv_sel, slv_we, slv_wdata, slv_addr, err_cnt);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (cpu_ready !== 1'b0 || slv_sel !== 8'h00) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_no_ready: ok=%b expected 1", ok);
    end
    // the next request completes normally
    cpu_req = 1'b1; cpu_addr = 32'h0000_0020;
    slv_rdata[0 +: DATA_W] = 32'h0bad_f00d;
    @(negedge clk);
    slv_ack = 8'h01;
    @(negedge clk);
    n_checks++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0bad_f00d) begin
      n_fail++; $display("FAIL rstmid_next: rdy=%b err=%b rdata=%h expected 1/0/0badf00d", cpu_ready, cpu_err, cpu_rdata);
    end
    slv_ack = 8'h00; cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_err_saturate();
    int exp_cnt;
    cpu_addr = 32'h5000_0000; cpu_we = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      cpu_req = 1'b1;
      @(negedge clk);
      cpu_req = 1'b0;
      @(negedge clk);
      exp_cnt = (n > 255) ? 255 : n;
      n_checks++;
      if (err_cnt !== exp_cnt[7:0]) begin
        n_fail++; $display("FAIL err_cnt n=%0d: got %0d expected %0d", n, err_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    slv_rdata = '0; slv_ack = 8'h00;
    test_reset();
    test_read();
    test_write_wait();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    test_err_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
